// File: rtl/bidi_updown_register_if.sv
// Control and status bundle for bidi_updown_register; the tri-state DATA bus stays a module port.
// Bus access: each cycle with ENABLE high is one access, RW=0 loads DATA on the edge, RW=1 drives REG onto DATA.
interface bidi_updown_register_if #(
    parameter int BUS_WIDTH = 16
);
    logic                 RW;
    logic                 ENABLE;
    logic                 COUNT;
    logic                 DOWN;
    logic [BUS_WIDTH-1:0] OUTPUT;
    logic                 ZERO;
    logic                 CARRY;

    modport master (
        output RW, ENABLE, COUNT, DOWN,
        input  OUTPUT, ZERO, CARRY
    );

    modport slave (
        input  RW, ENABLE, COUNT, DOWN,
        output OUTPUT, ZERO, CARRY
    );
endinterface

// File: rtl/bidi_updown_register.sv
// Bidirectional up/down counting register on a shared tri-state bus (PC / SP / loop counter).
// Optional build macro: SAT_COUNT_EN (saturate at the limits instead of wrapping).
module bidi_updown_register #(
    parameter int          BUS_WIDTH   = 16,
    parameter int unsigned STEP        = 1,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    bidi_updown_register_if.slave bus,
    inout  wire  [BUS_WIDTH-1:0] DATA
);
    localparam logic [BUS_WIDTH-1:0] STEP_W  = BUS_WIDTH'(STEP);
    localparam logic [BUS_WIDTH-1:0] RESET_W = BUS_WIDTH'(RESET_VALUE);

    logic [BUS_WIDTH-1:0] reg_q;
    logic                 carry_q;
    logic [BUS_WIDTH:0]   up_sum;
    logic [BUS_WIDTH-1:0] dn_diff;
    logic [BUS_WIDTH-1:0] next_count;
    logic                 count_clamp;
    logic                 bus_load;
    logic                 bus_drive;

    assign bus_load  = bus.ENABLE && !bus.RW;
    assign bus_drive = bus.ENABLE && bus.RW;

    // Clamp condition doubles as the wrap flag: a step of zero can never clamp.
    always_comb begin
        up_sum      = {1'b0, reg_q} + {1'b0, STEP_W};
        dn_diff     = reg_q - STEP_W;
        count_clamp = 1'b0;
        next_count  = reg_q;
        if (bus.DOWN) begin
            count_clamp = (reg_q < STEP_W);
`ifdef SAT_COUNT_EN
            next_count  = count_clamp ? '0 : dn_diff;
`else
            next_count  = dn_diff;
`endif
        end else begin
            count_clamp = up_sum[BUS_WIDTH];
`ifdef SAT_COUNT_EN
            next_count  = count_clamp ? '1 : up_sum[BUS_WIDTH-1:0];
`else
            next_count  = up_sum[BUS_WIDTH-1:0];
`endif
        end
    end

    // Reset beats load, load beats count; CARRY only survives one cycle.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            reg_q   <= RESET_W;
            carry_q <= 1'b0;
        end else if (bus_load) begin
            reg_q   <= DATA;
            carry_q <= 1'b0;
        end else if (bus.COUNT) begin
            reg_q   <= next_count;
            carry_q <= count_clamp;
        end else begin
            carry_q <= 1'b0;
        end
    end

    assign bus.OUTPUT = reg_q;
    assign bus.ZERO   = (reg_q == '0);
    assign bus.CARRY  = carry_q;
    assign DATA       = bus_drive ? reg_q : 'z;
endmodule
